md_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage SampleCPU core. It generates the `StallBus` vector that freezes or bubbles the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards between ID and EX, and runs a multi-cycle multiply/divide sequencer that holds the front of the pipe until the HI/LO result is ready. It sits beside ID/EX as the single source of `stall`, replacing per-stage `stallreq` OR-ing.

---
 rtl/md_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_md_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_hazard_ctrl.sv
// Pipeline sequencing controller: load-use hazard detect and multi-cycle mul/div hold.
// Latency: stall is combinational from ID/EX fields and FSM state; md_busy/md_done are registered-state derived.
// Backpressure: drives StallBus; MD hold (001111) outranks load-use bubble (000111); forced to 0 in reset.
module md_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic        ex_load,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  output logic [5:0]  stall,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] perf_stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The start cycle itself counts as one stall cycle, so BUSY covers N-1 more.
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);

  localparam logic [5:0] STALL_MD = 6'b001111;
  localparam logic [5:0] STALL_LU = 6'b000111;

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       md_stall;
  logic       lu;

  // Load-use: EX load targets a register ID is about to read; r0 never hazards.
  always_comb begin
    lu = id_valid & ex_load & ex_rf_we & (ex_rf_waddr != 5'd0) &
         ((id_use_rs & (id_rs == ex_rf_waddr)) |
          (id_use_rt & (id_rt == ex_rf_waddr)));
  end

  // State and countdown register; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sequencer next-state; start is only honoured from IDLE since BUSY/DONE hold the same instruction.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (ex_md_start) begin
          md_stall  = 1'b1;
          cnt_nxt   = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        md_stall = 1'b1;
        if (cnt == 6'd1) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 6'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // StallBus priority: reset > MD hold > load-use bubble (only outside BUSY) > run.
  always_comb begin
    stall = 6'b000000;
    if (rst) begin
      stall = 6'b000000;
    end else if (md_stall) begin
      stall = STALL_MD;
    end else if (lu && (state != BUSY)) begin
      stall = STALL_LU;
    end
  end

  // Status flags straight from the registered state.
  always_comb begin
    md_busy = (state != IDLE);
    md_done = (state == DONE);
  end

  // Count cycles in which the PC was frozen; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
    end else if (stall[0]) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Testbench for md_hazard_ctrl: directed scenarios plus randomized traffic.
// Outputs are sampled on the falling edge and compared to a cycle-count model.
// Inputs change 1 time unit after each rising edge.
module tb_md_hazard_ctrl;

  localparam int DIVN = 32;
  localparam int MULN = 2;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic        ex_load;
  logic        ex_md_start;
  logic        ex_md_is_div;
  logic [5:0]  stall;
  logic        md_busy;
  logic        md_done;
  logic [31:0] perf_stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  md_hazard_ctrl #(.DIV_CYCLES(DIVN), .MUL_CYCLES(MULN)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_use_rs         (id_use_rs),
    .id_use_rt         (id_use_rt),
    .ex_rf_we          (ex_rf_we),
    .ex_rf_waddr       (ex_rf_waddr),
    .ex_load           (ex_load),
    .ex_md_start       (ex_md_start),
    .ex_md_is_div      (ex_md_is_div),
    .stall             (stall),
    .md_busy           (md_busy),
    .md_done           (md_done),
    .perf_stall_cycles (perf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_left: BUSY cycles still owed after the start cycle; m_done: next cycle is the result cycle.
  int          m_left = 0;
  bit          m_done = 0;
  logic [31:0] m_perf = 0;

  always @(negedge clk) begin
    bit         hz;
    logic [5:0] e_stall;
    bit         e_busy, e_done;
    hz = id_valid && ex_load && ex_rf_we && (ex_rf_waddr != 0) &&
         ((id_use_rs && id_rs == ex_rf_waddr) || (id_use_rt && id_rt == ex_rf_waddr));
    e_busy = (m_left > 0) || m_done;
    e_done = (m_left == 0) && m_done;
    if (rst)              e_stall = 6'b000000;
    else if (m_left > 0)  e_stall = 6'b001111;
    else if (m_done)      e_stall = hz ? 6'b000111 : 6'b000000;
    else if (ex_md_start) e_stall = 6'b001111;
    else                  e_stall = hz ? 6'b000111 : 6'b000000;
    chk("model_stall", 32'(stall), 32'(e_stall));
    chk("model_md_busy", 32'(md_busy), 32'(e_busy));
    chk("model_md_done", 32'(md_done), 32'(e_done));
    chk("model_perf", perf_stall_cycles, m_perf);
    // advance to the state seen after the coming rising edge
    if (rst) begin
      m_left = 0; m_done = 0; m_perf = 0;
    end else begin
      m_perf = m_perf + 32'(e_stall[0]);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (m_done) begin
        m_done = 0;
      end else if (ex_md_start) begin
        m_left = (ex_md_is_div ? DIVN : MULN) - 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rf_we = 0; ex_rf_waddr = 0; ex_load = 0; ex_md_start = 0; ex_md_is_div = 0;
  endtask

  task automatic rnd_inputs();
    id_valid     = 1'($urandom);
    id_rs        = 5'($urandom_range(0, 3));
    id_rt        = 5'($urandom_range(0, 3));
    id_use_rs    = 1'($urandom);
    id_use_rt    = 1'($urandom);
    ex_rf_we     = 1'($urandom);
    ex_rf_waddr  = 5'($urandom_range(0, 3));
    ex_load      = 1'($urandom);
    ex_md_start  = ($urandom_range(0, 11) == 0);
    ex_md_is_div = 1'($urandom);
  endtask

  task automatic set_lu(input logic [4:0] r);
    id_valid = 1; id_rs = r; id_use_rs = 1;
    ex_load = 1; ex_rf_we = 1; ex_rf_waddr = r;
  endtask

  initial begin
    rst = 1;
    rnd_inputs();
    // reset with random inputs for two cycles
    step(); rnd_inputs();
    step();
    rst = 0; clr();
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_busy", 32'(md_busy), 32'h0);
    chk("reset_done", 32'(md_done), 32'h0);
    chk("reset_perf", perf_stall_cycles, 32'h0);

    // load-use on r8, then the same with r0
    step(); set_lu(5'd8);
    @(negedge clk);
    chk("lu_r8_stall", 32'(stall), 32'h07);
    step(); ex_rf_waddr = 0; id_rs = 0;
    @(negedge clk);
    chk("lu_r0_stall", 32'(stall), 32'h00);
    step(); clr(); rst = 1;
    step(); rst = 0;

    // divide: 32 stall cycles, done at T+32, perf = 32
    ex_md_start = 1; ex_md_is_div = 1;
    @(negedge clk);
    chk("div_stall_T", 32'(stall), 32'h0F);
    for (int k = 1; k <= DIVN; k++) begin
      step(); ex_md_start = 0;
      @(negedge clk);
      if (k < DIVN) begin
        chk("div_stall_busy", 32'(stall), 32'h0F);
        chk("div_no_early_done", 32'(md_done), 32'h0);
      end else begin
        chk("div_done", 32'(md_done), 32'h1);
        chk("div_done_stall", 32'(stall), 32'h00);
        chk("div_perf", perf_stall_cycles, 32'd32);
      end
    end
    step();
    @(negedge clk);
    chk("div_idle_after", 32'(md_busy), 32'h0);

    // multiply with start held through BUSY and DONE
    step(); ex_md_start = 1; ex_md_is_div = 0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) step();
      if (k == 3) ex_md_start = 0;
      @(negedge clk);
      chk("mul_stall", 32'(stall[0]), (k < 2) ? 32'h1 : 32'h0);
      chk("mul_done", 32'(md_done), (k == 2) ? 32'h1 : 32'h0);
    end
    chk("mul_no_restart", 32'(md_busy), 32'h0);

    // DONE cycle coinciding with a load-use hazard
    step(); ex_md_start = 1; ex_md_is_div = 0;
    step(); ex_md_start = 0;
    step(); set_lu(5'd5);
    @(negedge clk);
    chk("done_hz_done", 32'(md_done), 32'h1);
    chk("done_hz_stall", 32'(stall), 32'h07);
    step(); clr();

    // reset in the middle of a divide
    step(); ex_md_start = 1; ex_md_is_div = 1;
    for (int k = 1; k <= 10; k++) begin
      step(); ex_md_start = 0;
      if (k == 10) rst = 1;
    end
    step(); rst = 0;
    @(negedge clk);
    chk("abort_perf", perf_stall_cycles, 32'h0);
    chk("abort_busy", 32'(md_busy), 32'h0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(md_done), 32'h0);
      chk("abort_stall", 32'(stall), 32'h0);
      step();
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 149) == 0);
      rnd_inputs();
    end
    step(); rst = 0; clr();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
